apmu_ibex_instr_compressor: RTL and testbench

Streaming RV32I→RV32C compressor: accepts one 32-bit uncompressed instruction per handshake and rewrites it to its 16-bit compressed form when an exact RV32C equivalent exists. It packs the resulting 16/32-bit parcels into little-endian 32-bit words for the downstream instruction store. It is the encode-side counterpart of the core's compressed decoder: every compressed parcel it emits must decode back to the original instruction. It sits in the trace/instruction-image preparation path of the APMU, outside the core pipeline.

---
 rtl/apmu_ibex_instr_compressor_if.sv | 26 ++
 rtl/apmu_ibex_instr_compressor.sv | 221 ++++++++++++++++++++++
 tb/tb_apmu_ibex_instr_compressor.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apmu_ibex_instr_compressor_if.sv
// Handshake bundle for the RV32I->RV32C compressor: instruction in, packed words out,
// flush control and status.
interface apmu_ibex_instr_compressor_if #(
  parameter int CntWidth = 32
) ();
  logic                in_valid_i;
  logic [31:0]         in_instr_i;
  logic                in_ready_o;
  logic                flush_i;
  logic                flush_done_o;
  logic                out_valid_o;
  logic [31:0]         out_word_o;
  logic                out_ready_i;
  logic                err_o;
  logic [CntWidth-1:0] cnt_comp_o;

  modport slave (
    input  in_valid_i, in_instr_i, flush_i, out_ready_i,
    output in_ready_o, flush_done_o, out_valid_o, out_word_o, err_o, cnt_comp_o
  );

  modport master (
    output in_valid_i, in_instr_i, flush_i, out_ready_i,
    input  in_ready_o, flush_done_o, out_valid_o, out_word_o, err_o, cnt_comp_o
  );
endinterface

// File: rtl/apmu_ibex_instr_compressor.sv
// Streaming RV32I->RV32C compressor packing 16/32-bit parcels into little-endian words.
// One instruction per cycle; a completed word is visible one cycle after the accept.
module apmu_ibex_instr_compressor #(
  parameter bit CompressEn = 1'b1,
  parameter int CntWidth   = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  apmu_ibex_instr_compressor_if.slave  bus
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [15:0] C_NOP     = 16'h0001;

  typedef enum logic {
    ST_EMPTY,
    ST_HALF
  } state_t;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic        imm6_ok;
  logic        rd_p;
  logic        rs1_p;
  logic        rs2_p;

  assign instr   = bus.in_instr_i;
  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign funct7  = instr[31:25];
  assign imm_i   = instr[31:20];
  assign imm_s   = {instr[31:25], instr[11:7]};
  // Immediate fits the 6-bit signed CI field when bits [11:5] are pure sign extension.
  assign imm6_ok = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);
  assign rd_p    = (rd[4:3]  == 2'b01);
  assign rs1_p   = (rs1[4:3] == 2'b01);
  assign rs2_p   = (rs2[4:3] == 2'b01);

  logic        comp_vld;
  logic [15:0] comp_dat;
  logic [1:0]  arith_sel;
  logic        arith_ok;

  always_comb begin
    arith_sel = 2'b00;
    arith_ok  = 1'b0;
    if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
      arith_sel = 2'b00;
      arith_ok  = 1'b1;
    end else if (funct7 == 7'b0000000) begin
      case (funct3)
        3'b100:  begin arith_sel = 2'b01; arith_ok = 1'b1; end
        3'b110:  begin arith_sel = 2'b10; arith_ok = 1'b1; end
        3'b111:  begin arith_sel = 2'b11; arith_ok = 1'b1; end
        default: begin arith_sel = 2'b00; arith_ok = 1'b0; end
      endcase
    end
  end

  always_comb begin
    comp_vld = 1'b0;
    comp_dat = 16'h0000;
    case (opcode)
      OPC_OP_IMM: begin
        if (funct3 == 3'b000 && rd != 5'd0 && imm6_ok) begin
          if (rs1 == rd && imm_i != 12'd0) begin
            comp_vld = 1'b1;
            comp_dat = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
          end else if (rs1 == 5'd0) begin
            comp_vld = 1'b1;
            comp_dat = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
          end
        end
      end
      OPC_OP: begin
        if (funct3 == 3'b000 && funct7 == 7'd0 && rd != 5'd0 && rs2 != 5'd0
            && (rs1 == 5'd0 || rs1 == rd)) begin
          comp_vld = 1'b1;
          comp_dat = {3'b100, (rs1 != 5'd0), rd, rs2, 2'b10};
        end else if (arith_ok && rd_p && rs2_p && rs1 == rd) begin
          comp_vld = 1'b1;
          comp_dat = {6'b100011, rd[2:0], arith_sel, rs2[2:0], 2'b01};
        end
      end
      OPC_LOAD: begin
        if (funct3 == 3'b010 && imm_i[1:0] == 2'b00) begin
          if (rs1 == 5'd2 && rd != 5'd0 && imm_i[11:8] == 4'd0) begin
            comp_vld = 1'b1;
            comp_dat = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
          end else if (rd_p && rs1_p && imm_i[11:7] == 5'd0) begin
            comp_vld = 1'b1;
            comp_dat = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
          end
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010 && imm_s[1:0] == 2'b00) begin
          if (rs1 == 5'd2 && imm_s[11:8] == 4'd0) begin
            comp_vld = 1'b1;
            comp_dat = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
          end else if (rs2_p && rs1_p && imm_s[11:7] == 5'd0) begin
            comp_vld = 1'b1;
            comp_dat = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
          end
        end
      end
      OPC_JALR: begin
        if (funct3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0 && rd[4:1] == 4'd0) begin
          comp_vld = 1'b1;
          comp_dat = {3'b100, rd[0], rs1, 5'd0, 2'b10};
        end
      end
      default: begin
        if (instr == EBREAK) begin
          comp_vld = 1'b1;
          comp_dat = 16'h9002;
        end
      end
    endcase
  end

  state_t              state;
  logic [15:0]         residue;
  logic                out_valid;
  logic [31:0]         out_word;
  logic                flush_done;
  logic                err;
  logic [CntWidth-1:0] cnt;

  logic in_ready;
  logic accept;
  logic illegal;
  logic is_comp;
  logic flush_go;

  assign in_ready = !out_valid || bus.out_ready_i;
  assign accept   = bus.in_valid_i && in_ready;
  assign illegal  = (instr[1:0] != 2'b11);
  assign is_comp  = CompressEn && comp_vld;
  // Input traffic always wins; flush only drains into a free output register.
  assign flush_go = bus.flush_i && !bus.in_valid_i && in_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_EMPTY;
      residue    <= 16'h0000;
      out_valid  <= 1'b0;
      out_word   <= 32'h0000_0000;
      flush_done <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      flush_done <= 1'b0;
      err        <= 1'b0;
      if (out_valid && bus.out_ready_i) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (illegal) begin
          err <= 1'b1;
        end else begin
          if (is_comp && cnt != '1) begin
            cnt <= cnt + CntWidth'(1);
          end
          case (state)
            ST_EMPTY: begin
              if (is_comp) begin
                residue <= comp_dat;
                state   <= ST_HALF;
              end else begin
                out_word  <= instr;
                out_valid <= 1'b1;
              end
            end
            ST_HALF: begin
              out_valid <= 1'b1;
              if (is_comp) begin
                out_word <= {comp_dat, residue};
                state    <= ST_EMPTY;
              end else begin
                out_word <= {instr[15:0], residue};
                residue  <= instr[31:16];
              end
            end
            default: state <= ST_EMPTY;
          endcase
        end
      end else if (flush_go) begin
        flush_done <= 1'b1;
        if (state == ST_HALF) begin
          out_word  <= {C_NOP, residue};
          out_valid <= 1'b1;
          state     <= ST_EMPTY;
        end
      end
    end
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.out_valid_o  = out_valid;
  assign bus.out_word_o   = out_word;
  assign bus.flush_done_o = flush_done;
  assign bus.err_o        = err;
  assign bus.cnt_comp_o   = cnt;

endmodule

// File: tb/tb_apmu_ibex_instr_compressor.sv
// Scoreboard bench for the RV32I->RV32C compressor: expected words are queued as
// stimulus is driven and checked as the DUT hands words downstream.
module tb_apmu_ibex_instr_compressor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic [31:0] q[$];
  logic [31:0] q_nc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  apmu_ibex_instr_compressor_if #(.CntWidth(32)) bus ();
  apmu_ibex_instr_compressor_if #(.CntWidth(32)) bus0 ();

  apmu_ibex_instr_compressor #(.CompressEn(1'b1), .CntWidth(32)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  apmu_ibex_instr_compressor #(.CompressEn(1'b0), .CntWidth(32)) dut_nc (
    .clk_i(clk), .rst_i(rst), .bus(bus0)
  );

  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL word_unexpected got %h expected none", bus.out_word_o);
      end else begin
        logic [31:0] e;
        e = q.pop_front();
        if (bus.out_word_o !== e) begin
          fails++;
          $display("FAIL word_order got %h expected %h", bus.out_word_o, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus0.out_valid_o && bus0.out_ready_i) begin
      tests++;
      if (q_nc.size() == 0) begin
        fails++;
        $display("FAIL nc_word_unexpected got %h expected none", bus0.out_word_o);
      end else begin
        logic [31:0] e;
        e = q_nc.pop_front();
        if (bus0.out_word_o !== e) begin
          fails++;
          $display("FAIL nc_word got %h expected %h", bus0.out_word_o, e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins);
    int   n;
    logic rdy;
    n = 0;
    bus.in_valid_i = 1'b1;
    bus.in_instr_i = ins;
    do begin
      @(negedge clk);
      rdy = bus.in_ready_o;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    #1;
    bus.in_valid_i = 1'b0;
    tests++;
    if (!rdy) begin
      fails++;
      $display("FAIL send_timeout instr %h not accepted within %0d cycles", ins, n);
    end
  endtask

  task automatic send_nc(input logic [31:0] ins);
    int   n;
    logic rdy;
    n = 0;
    bus0.in_valid_i = 1'b1;
    bus0.in_instr_i = ins;
    do begin
      @(negedge clk);
      rdy = bus0.in_ready_o;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    #1;
    bus0.in_valid_i = 1'b0;
    tests++;
    if (!rdy) begin
      fails++;
      $display("FAIL nc_send_timeout instr %h not accepted within %0d cycles", ins, n);
    end
  endtask

  task automatic flush_check();
    int n;
    int pulses;
    n = 0;
    pulses = 0;
    bus.flush_i = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.flush_done_o && n < 50);
    bus.flush_i = 1'b0;
    if (bus.flush_done_o) pulses = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.flush_done_o) pulses++;
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL flush_done_pulses got %0d expected 1", pulses);
    end
  endtask

  task automatic check_drained(input string name);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_drained got %0d words outstanding expected 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid_o !== 1'b0 || bus.flush_done_o !== 1'b0 || bus.err_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags got v=%b fd=%b err=%b expected 0 0 0",
               bus.out_valid_o, bus.flush_done_o, bus.err_o);
    end
    tests++;
    if (bus.out_word_o !== 32'h0 || bus.cnt_comp_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_regs got word=%h cnt=%0d expected 0 0", bus.out_word_o, bus.cnt_comp_o);
    end
    tests++;
    if (bus.in_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b expected 1", bus.in_ready_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_pair();
    q.push_back(32'h4482_0405);
    send(32'h0014_0413);
    send(32'h0001_2483);
    check_drained("basic");
    tests++;
    if (bus.cnt_comp_o !== 32'd2) begin
      fails++;
      $display("FAIL basic_cnt got %0d expected 2", bus.cnt_comp_o);
    end
    flush_check();
    check_drained("basic_empty_flush");
  endtask

  task automatic test_flush_word();
    q.push_back(32'h0063_0405);
    q.push_back(32'h0001_0000);
    send(32'h0014_0413);
    send(32'h0000_0063);
    flush_check();
    check_drained("flush");
  endtask

  task automatic test_no_compress();
    q_nc.push_back(32'h0014_0413);
    q_nc.push_back(32'h0001_2483);
    send_nc(32'h0014_0413);
    send_nc(32'h0001_2483);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if (bus0.cnt_comp_o !== 32'd0 || q_nc.size() != 0) begin
      fails++;
      $display("FAIL no_compress got cnt=%0d pending=%0d expected 0 0",
               bus0.cnt_comp_o, q_nc.size());
    end
  endtask

  task automatic test_boundary();
    logic [31:0] ins [11] = '{
      32'h0204_0413, 32'hFE04_0413, 32'h0804_A403, 32'h07C4_A403,
      32'h0050_0033, 32'h0010_0073, 32'hFFF0_0513, 32'h00B0_0533,
      32'h4094_0433, 32'h0000_8067, 32'h0091_2223};
    logic [31:0] exp [11] = '{
      32'h0204_0413, 32'h0001_1401, 32'h0804_A403, 32'h0001_5CE0,
      32'h0050_0033, 32'h0001_9002, 32'h0001_557D, 32'h0001_852E,
      32'h0001_8C05, 32'h0001_8082, 32'h0001_C226};
    for (int i = 0; i < 11; i++) begin
      q.push_back(exp[i]);
      send(ins[i]);
      flush_check();
    end
    check_drained("boundary");
  endtask

  task automatic test_back_to_back();
    int c0;
    q.push_back(32'h0033_557D);
    q.push_back(32'h852E_0050);
    q.push_back(32'h8082_8C05);
    q.push_back(32'h0001_C226);
    c0 = cyc;
    send(32'hFFF0_0513);
    send(32'h0050_0033);
    send(32'h00B0_0533);
    send(32'h4094_0433);
    send(32'h0000_8067);
    send(32'h0091_2223);
    tests++;
    if (cyc - c0 != 6) begin
      fails++;
      $display("FAIL throughput got %0d cycles expected 6", cyc - c0);
    end
    flush_check();
    check_drained("b2b");
  endtask

  task automatic test_backpressure();
    logic [31:0] w [6] = '{
      32'h0000_0063, 32'h0020_8463, 32'h0000_0097,
      32'h0000_006F, 32'h1234_5037, 32'h4020_8033};
    for (int i = 0; i < 6; i++) q.push_back(w[i]);
    fork
      begin
        for (int i = 0; i < 6; i++) send(w[i]);
      end
      begin
        bus.out_ready_i = 1'b0;
        @(posedge clk);
        repeat (5) begin
          @(negedge clk);
          tests++;
          if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b1 || bus.out_word_o !== w[0]) begin
            fails++;
            $display("FAIL backpressure_hold got rdy=%b v=%b word=%h expected 0 1 %h",
                     bus.in_ready_o, bus.out_valid_o, bus.out_word_o, w[0]);
          end
        end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
      end
    join
    check_drained("backpressure");
  endtask

  task automatic test_illegal();
    q.push_back(32'h0063_0405);
    q.push_back(32'h0001_0000);
    send(32'h0014_0413);
    send(32'h0000_0001);
    tests++;
    if (bus.err_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL illegal_err got err=%b v=%b expected 1 0", bus.err_o, bus.out_valid_o);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.err_o !== 1'b0) begin
      fails++;
      $display("FAIL illegal_err_pulse got %b expected 0", bus.err_o);
    end
    send(32'h0000_0063);
    flush_check();
    check_drained("illegal");
  endtask

  task automatic test_reset_midstream();
    bus.out_ready_i = 1'b0;
    send(32'h0014_0413);
    send(32'h0000_0063);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    tests++;
    if (bus.out_valid_o !== 1'b0 || bus.cnt_comp_o !== 32'd0) begin
      fails++;
      $display("FAIL midreset got v=%b cnt=%0d expected 0 0", bus.out_valid_o, bus.cnt_comp_o);
    end
    flush_check();
    check_drained("midreset");
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_instr_i  = 32'h0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    bus0.in_valid_i  = 1'b0;
    bus0.in_instr_i  = 32'h0;
    bus0.flush_i     = 1'b0;
    bus0.out_ready_i = 1'b1;
    test_reset();
    test_basic_pair();
    test_flush_word();
    test_no_compress();
    test_boundary();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
